// File: rtl/ex_ma_reg.sv
// Execute -> memory-access pipeline register: two-entry skid buffer with registered in_ready,
// alignment check at capture, gated memory strobes and a saturating misalign counter.
module ex_ma_reg #(
  parameter int XLEN = 32,
  parameter int RDW  = 5,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ex_alu_res,
  input  logic [XLEN-1:0] ex_dataW,
  input  logic [2:0]      ex_mem_ctrl,
  input  logic            ex_memR,
  input  logic            ex_memW,
  input  logic [RDW-1:0]  ex_rd,
  input  logic            ex_regW,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ma_addr,
  output logic [XLEN-1:0] ma_dataW,
  output logic [2:0]      ma_mem_ctrl,
  output logic            ma_memR,
  output logic            ma_memW,
  output logic [RDW-1:0]  ma_rd,
  output logic            ma_regW,
  output logic            ma_misalign,
  output logic [CNTW-1:0] misalign_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] dataW;
    logic [2:0]      mem_ctrl;
    logic            memR;
    logic            memW;
    logic [RDW-1:0]  rd;
    logic            regW;
    logic            mis;
  } entry_t;

  entry_t          h_q, h_d, s_q, s_d, in_e;
  logic            hv_q, hv_d, sv_q, sv_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            accept, pop, size_mis;

  assign accept = in_valid & ~sv_q;
  assign pop    = hv_q & out_ready;

  // Low size bits pick the alignment rule; 011/110/111 fall through to word.
  always_comb begin
    case (ex_mem_ctrl[1:0])
      2'b00:   size_mis = 1'b0;
      2'b01:   size_mis = ex_alu_res[0];
      default: size_mis = |ex_alu_res[1:0];
    endcase
    in_e          = '0;
    in_e.addr     = ex_alu_res;
    in_e.dataW    = ex_dataW;
    in_e.mem_ctrl = ex_mem_ctrl;
    in_e.memR     = ex_memR;
    in_e.memW     = ex_memW;
    in_e.rd       = ex_rd;
    in_e.regW     = ex_regW;
    in_e.mis      = (ex_memR | ex_memW) & size_mis;
  end

  always_comb begin
    h_d   = h_q;
    s_d   = s_q;
    hv_d  = hv_q;
    sv_d  = sv_q;
    cnt_d = cnt_q;
    // A pop is consumed downstream even when a flush lands in the same cycle.
    if (pop && h_q.mis && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (flush) begin
      hv_d = 1'b0;
      sv_d = 1'b0;
    end else if (!hv_q) begin
      if (accept) begin
        h_d  = in_e;
        hv_d = 1'b1;
      end
    end else if (!sv_q) begin
      if (pop && accept) begin
        h_d = in_e;
      end else if (pop) begin
        hv_d = 1'b0;
      end else if (accept) begin
        s_d  = in_e;
        sv_d = 1'b1;
      end
    end else if (pop) begin
      h_d  = s_q;
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      s_q   <= '0;
      hv_q  <= 1'b0;
      sv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      h_q   <= h_d;
      s_q   <= s_d;
      hv_q  <= hv_d;
      sv_q  <= sv_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready     = ~sv_q;
  assign out_valid    = hv_q;
  assign ma_addr      = h_q.addr;
  assign ma_dataW     = h_q.dataW;
  assign ma_mem_ctrl  = h_q.mem_ctrl;
  assign ma_rd        = h_q.rd;
  assign ma_memR      = hv_q & h_q.memR & ~h_q.mis;
  assign ma_memW      = hv_q & h_q.memW & ~h_q.mis;
  assign ma_regW      = hv_q & h_q.regW & ~h_q.mis;
  assign ma_misalign  = hv_q & h_q.mis;
  assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_ex_ma_reg.sv
// Bench for ex_ma_reg: directed scenarios plus random traffic against a queue-based model.
module tb_ex_ma_reg;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] ex_alu_res, ex_dataW;
  logic [2:0]  ex_mem_ctrl;
  logic        ex_memR, ex_memW, ex_regW;
  logic [4:0]  ex_rd;

  logic        in_ready, out_valid, ma_memR, ma_memW, ma_regW, ma_misalign;
  logic [31:0] ma_addr, ma_dataW;
  logic [2:0]  ma_mem_ctrl;
  logic [4:0]  ma_rd;
  logic [7:0]  misalign_cnt;

  logic        b_in_ready, b_out_valid, b_memR, b_memW, b_regW, b_mis;
  logic [31:0] b_addr, b_dataW;
  logic [2:0]  b_ctrl;
  logic [4:0]  b_rd;
  logic [1:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_ma_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ex_alu_res(ex_alu_res), .ex_dataW(ex_dataW), .ex_mem_ctrl(ex_mem_ctrl),
    .ex_memR(ex_memR), .ex_memW(ex_memW), .ex_rd(ex_rd), .ex_regW(ex_regW),
    .out_valid(out_valid), .out_ready(out_ready), .ma_addr(ma_addr), .ma_dataW(ma_dataW),
    .ma_mem_ctrl(ma_mem_ctrl), .ma_memR(ma_memR), .ma_memW(ma_memW), .ma_rd(ma_rd),
    .ma_regW(ma_regW), .ma_misalign(ma_misalign), .misalign_cnt(misalign_cnt)
  );

  ex_ma_reg #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .ex_alu_res(ex_alu_res), .ex_dataW(ex_dataW), .ex_mem_ctrl(ex_mem_ctrl),
    .ex_memR(ex_memR), .ex_memW(ex_memW), .ex_rd(ex_rd), .ex_regW(ex_regW),
    .out_valid(b_out_valid), .out_ready(out_ready), .ma_addr(b_addr), .ma_dataW(b_dataW),
    .ma_mem_ctrl(b_ctrl), .ma_memR(b_memR), .ma_memW(b_memW), .ma_rd(b_rd),
    .ma_regW(b_regW), .ma_misalign(b_mis), .misalign_cnt(b_cnt)
  );

  // Reference model: an in-order queue of at most two ops.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] dataW;
    logic [2:0]  ctrl;
    logic        r, w, regW, mis;
    logic [4:0]  rd;
  } ent_t;

  ent_t m_q[$];
  ent_t m_head;
  int   m_cnt8 = 0;
  int   m_cnt2 = 0;

  function automatic logic mis_of(logic [31:0] a, logic [2:0] c, logic r, logic w);
    int sz;
    sz = (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
    return (r || w) && ((a % sz) != 0);
  endfunction

  always @(posedge clk) begin
    int   n;
    logic popped, acc;
    ent_t e;
    n      = m_q.size();
    popped = (n > 0) && out_ready;
    acc    = in_valid && (n < 2);
    if (rst) begin
      m_q.delete();
      m_head = '{default: '0};
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (popped && m_q[0].mis) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (flush) m_q.delete();
      else begin
        if (popped) void'(m_q.pop_front());
        if (acc) begin
          e.addr = ex_alu_res; e.dataW = ex_dataW; e.ctrl = ex_mem_ctrl;
          e.r = ex_memR; e.w = ex_memW; e.regW = ex_regW; e.rd = ex_rd;
          e.mis = mis_of(ex_alu_res, ex_mem_ctrl, ex_memR, ex_memW);
          m_q.push_back(e);
        end
      end
      if (m_q.size() > 0) m_head = m_q[0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] a, input logic [2:0] c,
                        input logic r, input logic w, input logic rw);
    in_valid = v; ex_alu_res = a; ex_dataW = a ^ 32'hA5A5_0000;
    ex_mem_ctrl = c; ex_memR = r; ex_memW = w; ex_regW = rw; ex_rd = a[6:2];
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b0;
    set_op(1'b1, 32'h44, 3'b010, 1'b0, 1'b1, 1'b0);
    step(); step();
    do_reset();
    tests++;
    if ({in_ready, out_valid, ma_memR, ma_memW, ma_regW, ma_misalign} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags got %b want 100000",
               {in_ready, out_valid, ma_memR, ma_memW, ma_regW, ma_misalign});
    end
    tests++;
    if ({ma_addr, ma_dataW, ma_mem_ctrl, ma_rd, misalign_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_data got addr=%h data=%h ctrl=%b rd=%0d cnt=%0d want all 0",
               ma_addr, ma_dataW, ma_mem_ctrl, ma_rd, misalign_cnt);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, 32'(4 * i), 3'b010, 1'b1, 1'b0, 1'b1);
      step();
      tests++;
      if ({out_valid, ma_memR, in_ready, ma_addr} !== {3'b111, 32'(4 * i)}) begin
        fails++;
        $display("FAIL stream_%0d got v/memR/rdy=%b%b%b addr=%h want 111 addr=%h",
                 i, out_valid, ma_memR, in_ready, ma_addr, 32'(4 * i));
      end
    end
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(1'b1, 32'h10, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    set_op(1'b1, 32'h14, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({in_ready, out_valid, ma_memW, ma_addr} !== {3'b011, 32'h10}) begin
      fails++;
      $display("FAIL bp_full got rdy/v/memW=%b%b%b addr=%h want 011 addr=10",
               in_ready, out_valid, ma_memW, ma_addr);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if ({in_ready, out_valid, ma_addr, ma_dataW} !== {2'b11, 32'h14, 32'hA5A5_0014}) begin
      fails++;
      $display("FAIL bp_pop1 got rdy/v=%b%b addr=%h data=%h want 11 addr=14 data=a5a50014",
               in_ready, out_valid, ma_addr, ma_dataW);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_pop2 got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    out_ready = 1'b1;
    set_op(1'b1, 32'h101, 3'b001, 1'b0, 1'b1, 1'b0);
    step();
    tests++;
    if ({ma_misalign, ma_memW, ma_regW} !== 3'b100) begin
      fails++;
      $display("FAIL mis_half got mis/memW/regW=%b want 100", {ma_misalign, ma_memW, ma_regW});
    end
    set_op(1'b1, 32'h102, 3'b010, 1'b1, 1'b0, 1'b1);
    step();
    tests++;
    if ({ma_misalign, ma_memR, ma_regW, misalign_cnt} !== {3'b100, 8'd1}) begin
      fails++;
      $display("FAIL mis_word got mis/memR/regW=%b cnt=%0d want 100 cnt=1",
               {ma_misalign, ma_memR, ma_regW}, misalign_cnt);
    end
    set_op(1'b1, 32'h103, 3'b000, 1'b1, 1'b0, 1'b1);
    step();
    tests++;
    if ({ma_misalign, ma_memR, ma_regW} !== 3'b011) begin
      fails++;
      $display("FAIL mis_byte got mis/memR/regW=%b want 011", {ma_misalign, ma_memR, ma_regW});
    end
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (misalign_cnt !== 8'd2) begin
      fails++;
      $display("FAIL mis_count got %0d want 2", misalign_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_op(1'b1, 32'h20, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    set_op(1'b1, 32'h24, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    set_op(1'b1, 32'h28, 3'b010, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if ({out_valid, in_ready, ma_memW} !== 3'b010) begin
      fails++;
      $display("FAIL flush_full got v/rdy/memW=%b want 010", {out_valid, in_ready, ma_memW});
    end
    // Flush with room to accept: the presented op must still be dropped.
    set_op(1'b1, 32'h30, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    set_op(1'b1, 32'h34, 3'b010, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_drop got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(1'b1, 32'(16 * i + 1), 3'b010, 1'b1, 1'b0, 1'b1);
      step();
    end
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (b_cnt !== 2'd3) begin
      fails++;
      $display("FAIL sat_cnt2 got %0d want 3", b_cnt);
    end
    tests++;
    if (misalign_cnt !== 8'd5) begin
      fails++;
      $display("FAIL sat_cnt8 got %0d want 5", misalign_cnt);
    end
  endtask

  task automatic test_midop_reset();
    out_ready = 1'b0;
    set_op(1'b1, 32'h40, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    set_op(1'b1, 32'h44, 3'b010, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({out_valid, ma_memW, in_ready, misalign_cnt, b_cnt} !== {3'b001, 8'd0, 2'd0}) begin
      fails++;
      $display("FAIL midop_rst got v/memW/rdy=%b%b%b cnt=%0d cnt2=%0d want 001 0 0",
               out_valid, ma_memW, in_ready, misalign_cnt, b_cnt);
    end
  endtask

  task automatic test_random();
    int   n;
    ent_t hd;
    logic hv;
    logic [5:0]  ef;
    logic [71:0] ed;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      flush     = ($urandom_range(0, 99) < 5);
      out_ready = ($urandom_range(0, 99) < 60);
      set_op($urandom_range(0, 99) < 70, {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      n  = m_q.size();
      hd = m_head;
      hv = (n > 0);
      ef = {hv, n < 2, hv & hd.r & ~hd.mis, hv & hd.w & ~hd.mis, hv & hd.regW & ~hd.mis, hv & hd.mis};
      ed = {hd.addr, hd.dataW, hd.ctrl, hd.rd};
      tests++;
      if ({out_valid, in_ready, ma_memR, ma_memW, ma_regW, ma_misalign} !== ef) begin
        fails++;
        $display("FAIL rand_flags[%0d] got %b want %b", i,
                 {out_valid, in_ready, ma_memR, ma_memW, ma_regW, ma_misalign}, ef);
      end
      tests++;
      if ({ma_addr, ma_dataW, ma_mem_ctrl, ma_rd} !== ed) begin
        fails++;
        $display("FAIL rand_data[%0d] got %h want %h", i, {ma_addr, ma_dataW, ma_mem_ctrl, ma_rd}, ed);
      end
      tests++;
      if (misalign_cnt !== 8'(m_cnt8) || b_cnt !== 2'(m_cnt2)) begin
        fails++;
        $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, misalign_cnt, b_cnt, m_cnt8, m_cnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_op(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_misalign();
    test_flush();
    test_saturation();
    test_midop_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
